// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: debounced one-hot hex keypad front end driving digit writes, cursor and clear.
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter bit AUTO_ADV = 1'b1
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [15:0] pb,
  input  logic        left_btn,
  input  logic        right_btn,
  input  logic        clr_btn,
  output logic        wr_en,
  output logic [2:0]  wr_idx,
  output logic [3:0]  wr_data,
  output logic        clear_all,
  output logic [2:0]  cursor,
  output logic [7:0]  flt_pt,
  output logic        busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, ARM, COMMIT, WAIT_REL} state_t;
  state_t state;
  logic [15:0] pb_m, pb_s, key;
  logic [2:0] btn_m, btn_s, btn_d;
  logic l_e, r_e, c_e, one_hot;
  logic [3:0] enc;
  logic [CW-1:0] cnt;
  logic [2:0] cursor_nxt;
  assign {c_e, l_e, r_e} = btn_s & ~btn_d;
  assign one_hot = (pb_s != '0) && ((pb_s & (pb_s - 16'd1)) == '0);
  always_comb begin
    enc = '0;
    for (int i = 0; i < 16; i++) if (key[i]) enc = 4'(i);
  end
  // A clear wins over advance and shifts; simultaneous left/right cancel arithmetically.
  assign cursor_nxt = c_e ? 3'd0 : cursor + 3'((state == COMMIT) && AUTO_ADV) + 3'(l_e) - 3'(r_e);
  assign flt_pt = 8'd1 << cursor;
  assign busy = state != IDLE;
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state <= IDLE;
      pb_m <= '0;
      pb_s <= '0;
      key <= '0;
      btn_m <= '0;
      btn_s <= '0;
      btn_d <= '0;
      cnt <= '0;
      cursor <= '0;
      wr_en <= 1'b0;
      wr_idx <= '0;
      wr_data <= '0;
      clear_all <= 1'b0;
    end else begin
      pb_m <= pb;
      pb_s <= pb_m;
      btn_m <= {clr_btn, left_btn, right_btn};
      btn_s <= btn_m;
      btn_d <= btn_s;
      cursor <= cursor_nxt;
      wr_en <= 1'b0;
      clear_all <= c_e;
      if (c_e) begin
        state <= WAIT_REL;
        cnt <= '0;
      end else begin
        case (state)
          IDLE:
            if (one_hot) begin
              state <= ARM;
              key <= pb_s;
              cnt <= CW'(1);
            end else if (pb_s != '0) begin
              state <= WAIT_REL;
              cnt <= '0;
            end
          ARM:
            if (pb_s == key) begin
              if (cnt == CMAX) state <= COMMIT;
              else cnt <= cnt + CW'(1);
            end else if (pb_s == '0) state <= IDLE;
            else begin
              state <= WAIT_REL;
              cnt <= '0;
            end
          COMMIT: begin
            wr_en <= 1'b1;
            wr_idx <= cursor;
            wr_data <= enc;
            state <= WAIT_REL;
            cnt <= '0;
          end
          WAIT_REL:
            if (pb_s != '0) cnt <= '0;
            else if (cnt == CMAX) state <= IDLE;
            else cnt <= cnt + CW'(1);
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: directed checks of debounce timing, rejection, cursor wrap and clear override.
module tb_keypad_entry_ctrl;
  logic CLK = 1'b0;
  logic NRST = 1'b0;
  logic [15:0] pb = '0;
  logic left_btn = 1'b0, right_btn = 1'b0, clr_btn = 1'b0;
  logic wr_en, clear_all, busy;
  logic [2:0] wr_idx, cursor;
  logic [3:0] wr_data;
  logic [7:0] flt_pt;
  int passed = 0, total = 0;

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_ADV(1'b1)) dut (
    .CLK(CLK), .NRST(NRST), .pb(pb), .left_btn(left_btn), .right_btn(right_btn),
    .clr_btn(clr_btn), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .clear_all(clear_all), .cursor(cursor), .flt_pt(flt_pt), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic pulse(input bit l, input bit r);
    left_btn = l;
    right_btn = r;
    step(2);
    left_btn = 1'b0;
    right_btn = 1'b0;
    step(3);
  endtask

  task automatic test_reset;
    NRST = 1'b0;
    step(3);
    total++; if (cursor !== 3'd0) $display("FAIL reset_cursor got %0d want 0", cursor); else passed++;
    total++; if (flt_pt !== 8'h01) $display("FAIL reset_flt_pt got %h want 01", flt_pt); else passed++;
    total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else passed++;
    total++; if (clear_all !== 1'b0) $display("FAIL reset_clear_all got %b want 0", clear_all); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    NRST = 1'b1;
    step(2);
  endtask

  task automatic test_single_key;
    int wcnt = 0, wat = -1, idle_at = -1;
    logic [2:0] idx = 'x;
    logic [3:0] dat = 'x;
    pb = 16'h0400;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (wr_en === 1'b1) begin
        wcnt++;
        if (wat < 0) begin wat = i; idx = wr_idx; dat = wr_data; end
      end
    end
    total++; if (wcnt != 1) $display("FAIL single_wr_count got %0d want 1", wcnt); else passed++;
    total++; if (wat != 7) $display("FAIL single_latency got %0d want 7", wat); else passed++;
    total++; if (idx !== 3'd0) $display("FAIL single_wr_idx got %0d want 0", idx); else passed++;
    total++; if (dat !== 4'hA) $display("FAIL single_wr_data got %h want a", dat); else passed++;
    total++; if (cursor !== 3'd1) $display("FAIL single_cursor got %0d want 1", cursor); else passed++;
    pb = '0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (busy === 1'b0 && idle_at < 0) idle_at = i;
    end
    total++; if (idle_at != 6) $display("FAIL single_release got %0d want 6", idle_at); else passed++;
  endtask

  task automatic test_multi_key;
    int wcnt = 0, idle_at = -1;
    pb = 16'h0012;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (wr_en === 1'b1) wcnt++;
    end
    total++; if (wcnt != 0) $display("FAIL multi_wr_count got %0d want 0", wcnt); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL multi_busy got %b want 1", busy); else passed++;
    pb = '0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (busy === 1'b0 && idle_at < 0) idle_at = i;
    end
    total++; if (idle_at != 6) $display("FAIL multi_release got %0d want 6", idle_at); else passed++;
  endtask

  task automatic test_glitch;
    int wcnt = 0;
    pb = 16'h0008;
    step(2);
    pb = '0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (wr_en === 1'b1) wcnt++;
    end
    total++; if (wcnt != 0) $display("FAIL glitch_wr_count got %0d want 0", wcnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL glitch_busy got %b want 0", busy); else passed++;
    total++; if (cursor !== 3'd1) $display("FAIL glitch_cursor got %0d want 1", cursor); else passed++;
  endtask

  task automatic test_wrap;
    int wcnt = 0;
    logic [2:0] idx = 'x;
    logic [3:0] dat = 'x;
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    total++; if (cursor !== 3'd7) $display("FAIL wrap_right_cursor got %0d want 7", cursor); else passed++;
    total++; if (flt_pt !== 8'h80) $display("FAIL wrap_flt_pt got %h want 80", flt_pt); else passed++;
    pb = 16'h0020;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (wr_en === 1'b1) begin wcnt++; idx = wr_idx; dat = wr_data; end
    end
    pb = '0;
    step(10);
    total++; if (wcnt != 1) $display("FAIL wrap_wr_count got %0d want 1", wcnt); else passed++;
    total++; if (idx !== 3'd7) $display("FAIL wrap_wr_idx got %0d want 7", idx); else passed++;
    total++; if (dat !== 4'h5) $display("FAIL wrap_wr_data got %h want 5", dat); else passed++;
    total++; if (cursor !== 3'd0) $display("FAIL wrap_adv_cursor got %0d want 0", cursor); else passed++;
    pulse(1'b0, 1'b1);
    total++; if (cursor !== 3'd7) $display("FAIL wrap_right2_cursor got %0d want 7", cursor); else passed++;
    pulse(1'b1, 1'b1);
    total++; if (cursor !== 3'd7) $display("FAIL wrap_cancel_cursor got %0d want 7", cursor); else passed++;
    pulse(1'b1, 1'b0);
    total++; if (cursor !== 3'd0) $display("FAIL wrap_left_cursor got %0d want 0", cursor); else passed++;
    pulse(1'b1, 1'b0);
    total++; if (cursor !== 3'd1) $display("FAIL wrap_left2_cursor got %0d want 1", cursor); else passed++;
  endtask

  task automatic test_clear;
    int wcnt = 0, ccnt = 0, cat = -1;
    pb = 16'h0001;
    for (int i = 0; i < 15; i++) begin
      if (i == 5) clr_btn = 1'b1;
      if (i == 8) clr_btn = 1'b0;
      step(1);
      if (wr_en === 1'b1) wcnt++;
      if (clear_all === 1'b1) begin ccnt++; if (cat < 0) cat = i; end
    end
    total++; if (wcnt != 0) $display("FAIL clear_wr_count got %0d want 0", wcnt); else passed++;
    total++; if (ccnt != 1) $display("FAIL clear_count got %0d want 1", ccnt); else passed++;
    total++; if (cat != 7) $display("FAIL clear_timing got %0d want 7", cat); else passed++;
    total++; if (cursor !== 3'd0) $display("FAIL clear_cursor got %0d want 0", cursor); else passed++;
    pb = '0;
    step(10);
    total++; if (busy !== 1'b0) $display("FAIL clear_release_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_async_reset;
    pulse(1'b1, 1'b0);
    total++; if (cursor !== 3'd1) $display("FAIL async_pre_cursor got %0d want 1", cursor); else passed++;
    #2 NRST = 1'b0;
    #1;
    total++; if (cursor !== 3'd0) $display("FAIL async_cursor got %0d want 0", cursor); else passed++;
    total++; if (flt_pt !== 8'h01) $display("FAIL async_flt_pt got %h want 01", flt_pt); else passed++;
    @(negedge CLK);
    NRST = 1'b1;
    step(2);
  endtask

  initial begin
    @(negedge CLK);
    test_reset;
    test_single_key;
    test_multi_key;
    test_glitch;
    test_wrap;
    test_clear;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
